spi_xfer_seq: RTL

SPI_XFER_SEQ -- requirements
Module: spi_xfer_seq

---
 rtl/spi_xfer_seq.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/spi_xfer_seq.sv
// spi_xfer_seq: buffered SPI byte-transfer sequencer for a shared flash/MCU bus and a TF bus.
// Bytes are read from and written back to an external buffer, SPI mode 0, MSB first.
module spi_xfer_seq #(
   parameter int LEN_W = 9,
   parameter int DIV_W = 4
) (
   input  logic             FastClk,
   input  logic             nReset,
   input  logic             Start,
   input  logic             Abort,
   input  logic [1:0]       Dev,
   input  logic [1:0]       Mode,
   input  logic [LEN_W-1:0] Len,
   input  logic [DIV_W-1:0] ClkDiv,
   output logic             Busy,
   output logic             Done,
   output logic [LEN_W-1:0] BufAddr,
   input  logic [7:0]       BufRData,
   output logic [7:0]       BufWData,
   output logic             BufWE,
   output logic             SPIClk,
   output logic             SPIDo,
   input  logic             SPIDi,
   output logic             TFClk,
   output logic             TFDo,
   input  logic             TFDi,
   output logic             nFlashSel,
   output logic             nMCUSel,
   output logic             nTFSel
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD   = 3'd1;
   localparam logic [2:0] S_SHIFT  = 3'd2;
   localparam logic [2:0] S_STORE  = 3'd3;
   localparam logic [2:0] S_FINISH = 3'd4;

   localparam logic [1:0] DEV_FLASH = 2'd0;
   localparam logic [1:0] DEV_MCU   = 2'd1;
   localparam logic [1:0] DEV_TF    = 2'd2;
   localparam logic [1:0] MODE_TX   = 2'd1;
   localparam logic [1:0] MODE_RX   = 2'd2;

   logic [2:0]       r_state;
   logic [2:0]       w_next;
   logic [1:0]       r_dev;
   logic [1:0]       r_mode;
   logic [LEN_W-1:0] r_len;
   logic [LEN_W-1:0] r_idx;
   logic [DIV_W-1:0] r_div;
   logic [DIV_W-1:0] r_cnt;
   logic             r_phase;
   logic [2:0]       r_bit;
   logic [7:0]       r_sh;
   logic             r_rxb;

   logic w_start;
   logic w_busy;
   logic w_cnt_zero;
   logic w_last_bit;
   logic w_last_byte;
   logic w_di;
   logic w_sclk;
   logic w_do;
   logic w_tf;

   assign w_start     = (r_state == S_IDLE) & Start & ~Abort & (Dev != 2'd3) & (Mode != 2'd3);
   assign w_busy      = (r_state == S_LOAD) | (r_state == S_SHIFT) | (r_state == S_STORE);
   assign w_cnt_zero  = (r_cnt == '0);
   assign w_last_bit  = r_phase & w_cnt_zero & (r_bit == 3'd7);
   assign w_last_byte = (r_idx == r_len);
   assign w_tf        = (r_dev == DEV_TF);
   assign w_di        = w_tf ? TFDi : SPIDi;
   assign w_sclk      = (r_state == S_SHIFT) & r_phase;
   assign w_do        = (r_state == S_SHIFT) ? r_sh[7] : 1'b1;

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:   if (w_start) w_next = S_LOAD;
         S_LOAD:   w_next = Abort ? S_IDLE : S_SHIFT;
         S_SHIFT: begin
            if (Abort)           w_next = S_IDLE;
            else if (w_last_bit) w_next = S_STORE;
         end
         S_STORE: begin
            if (Abort)            w_next = S_IDLE;
            else if (w_last_byte) w_next = S_FINISH;
            else                  w_next = S_LOAD;
         end
         S_FINISH: w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge FastClk or negedge nReset) begin
      if (!nReset) begin
         r_state <= S_IDLE;
         r_dev   <= '0;
         r_mode  <= '0;
         r_len   <= '0;
         r_div   <= '0;
         r_idx   <= '0;
         r_cnt   <= '0;
         r_phase <= 1'b0;
         r_bit   <= '0;
         r_sh    <= '0;
         r_rxb   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_start) begin
            r_dev  <= Dev;
            r_mode <= Mode;
            r_len  <= Len;
            r_div  <= ClkDiv;
            r_idx  <= '0;
         end
         if (r_state == S_LOAD) begin
            r_sh    <= (r_mode == MODE_RX) ? 8'hFF : BufRData;
            r_cnt   <= r_div;
            r_phase <= 1'b0;
            r_bit   <= '0;
         end
         // Di is captured on the rising SPI edge, shifted in on the falling edge
         // so Do only changes while the clock is going low.
         if (r_state == S_SHIFT) begin
            if (w_cnt_zero) begin
               r_cnt   <= r_div;
               r_phase <= ~r_phase;
               if (!r_phase) begin
                  r_rxb <= w_di;
               end else begin
                  r_sh  <= {r_sh[6:0], r_rxb};
                  r_bit <= r_bit + 3'd1;
               end
            end else begin
               r_cnt <= r_cnt - 1'b1;
            end
         end
         if ((r_state == S_STORE) && (w_next == S_LOAD)) r_idx <= r_idx + 1'b1;
      end
   end

   assign Busy      = w_busy;
   assign Done      = (r_state == S_FINISH);
   assign BufAddr   = r_idx;
   assign BufWData  = r_sh;
   assign BufWE     = (r_state == S_STORE) & (r_mode != MODE_TX) & ~Abort;

   assign SPIClk    = w_sclk & ~w_tf;
   assign SPIDo     = w_tf ? 1'b1 : w_do;
   assign TFClk     = w_sclk & w_tf;
   assign TFDo      = w_tf ? w_do : 1'b1;

   assign nFlashSel = ~(w_busy & (r_dev == DEV_FLASH));
   assign nMCUSel   = ~(w_busy & (r_dev == DEV_MCU));
   assign nTFSel    = ~(w_busy & w_tf);

endmodule
